pwm_bridge_ctrl: RTL and testbench

Multi-channel PWM generator and H-bridge sequencer for the rover drive motors. It is the parametrised successor to the single-channel `pwm` plus `switch` pair. It generates one PWM enable per bridge, ramps the applied duty, inserts coast time on direction reversal, and latches per-channel overcurrent faults with a lockout and explicit clear. It sits between the switch/duty decode logic and the motor-driver pins (`EN`, `IN`).

---
 rtl/pwm_bridge_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pwm_bridge_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_bridge_ctrl.sv
// Multi-channel PWM generator and H-bridge sequencer: duty ramping, coast on
// reversal, and latched overcurrent lockout with explicit clear.
module pwm_bridge_ctrl #(
  parameter int CH      = 2,
  parameter int CW      = 20,
  parameter int PERIOD  = 1000000,
  parameter int STEP    = 65536,
  parameter int DEAD    = 2,
  parameter int LOCKOUT = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*CW-1:0] duty,
  input  logic [CH-1:0]    dir,
  input  logic [CH-1:0]    OC,
  input  logic             oc_clr,
  output logic [CH-1:0]    EN,
  output logic [2*CH-1:0]  IN,
  output logic [CH-1:0]    fault,
  output logic             period_start
);

  localparam int CNTW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int MAXP   = (DEAD > LOCKOUT) ? DEAD : LOCKOUT;
  localparam int PCW    = (MAXP > 1) ? $clog2(MAXP + 1) : 1;
  localparam int STEP_C = (STEP > PERIOD) ? PERIOD : STEP;

  localparam logic [CW:0]     PERIOD_W = (CW+1)'(PERIOD);
  localparam logic [CW:0]     STEP_W   = (CW+1)'(STEP_C);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(PERIOD - 1);
  localparam logic [PCW-1:0]  DEAD_W   = PCW'(DEAD);
  localparam logic [PCW-1:0]  LOCK_W   = PCW'(LOCKOUT);

  typedef enum logic [1:0] {S_RUN, S_DEAD, S_FAULT} state_t;

  logic [CNTW-1:0] cnt_reg;
  logic [CW:0]     cnt_w;
  logic            boundary;
  logic            period_start_reg;

  assign boundary     = (cnt_reg == LAST_CNT);
  assign cnt_w        = (CW+1)'(cnt_reg);
  assign period_start = period_start_reg;

  // period_start marks the cycle where the (one-cycle lagged) EN window opens
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= boundary ? '0 : cnt_reg + CNTW'(1);
      period_start_reg <= (cnt_reg == '0);
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_t         state_reg;
    logic [1:0]     oc_sync_reg;
    logic           oc_s;
    logic [CW:0]    cur_reg;
    logic [CW:0]    tgt;
    logic [CW:0]    ramp_next;
    logic [PCW-1:0] pcnt_reg;
    logic           expired;
    logic           dir_q_reg;
    logic           clr_seen_reg;
    logic           en_reg;
    logic [1:0]     in_reg;
    logic           fault_reg;

    assign oc_s    = oc_sync_reg[1];
    assign expired = (pcnt_reg == '0);

    // target clamped to a full period; ramp done one bit wide so nothing wraps
    always_comb begin
      tgt       = ({1'b0, duty[gi*CW +: CW]} > PERIOD_W) ? PERIOD_W : {1'b0, duty[gi*CW +: CW]};
      ramp_next = cur_reg;
      if (tgt > cur_reg) begin
        ramp_next = ((tgt - cur_reg) <= STEP_W) ? tgt : cur_reg + STEP_W;
      end else if (tgt < cur_reg) begin
        ramp_next = ((cur_reg - tgt) <= STEP_W) ? tgt : cur_reg - STEP_W;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg    <= S_DEAD;
        oc_sync_reg  <= 2'b00;
        cur_reg      <= '0;
        pcnt_reg     <= DEAD_W;
        dir_q_reg    <= 1'b0;
        clr_seen_reg <= 1'b0;
        en_reg       <= 1'b0;
        in_reg       <= 2'b00;
        fault_reg    <= 1'b0;
      end else begin
        oc_sync_reg <= {oc_sync_reg[0], OC[gi]};
        // outputs are gated by the synchronised OC directly so the bridge
        // coasts on the same edge the state machine enters FAULT
        en_reg <= !oc_s && (state_reg == S_RUN) && (cnt_w < cur_reg);
        in_reg <= (oc_s || state_reg != S_RUN) ? 2'b00 : (dir_q_reg ? 2'b01 : 2'b10);

        if (oc_s) begin
          state_reg    <= S_FAULT;
          cur_reg      <= '0;
          fault_reg    <= 1'b1;
          pcnt_reg     <= LOCK_W;
          clr_seen_reg <= 1'b0;
        end else begin
          case (state_reg)
            S_RUN: begin
              if (boundary) begin
                if (dir[gi] != dir_q_reg) begin
                  state_reg <= S_DEAD;
                  cur_reg   <= '0;
                  pcnt_reg  <= DEAD_W;
                end else begin
                  cur_reg <= ramp_next;
                end
              end
            end
            S_DEAD: begin
              if (boundary) begin
                if (pcnt_reg <= PCW'(1)) begin
                  state_reg <= S_RUN;
                  dir_q_reg <= dir[gi];
                  cur_reg   <= '0;
                  pcnt_reg  <= '0;
                end else begin
                  pcnt_reg <= pcnt_reg - PCW'(1);
                end
              end
            end
            S_FAULT: begin
              // a clear only counts once the lockout has run out
              if (expired && oc_clr) clr_seen_reg <= 1'b1;
              if (boundary) begin
                if (!expired) begin
                  pcnt_reg <= pcnt_reg - PCW'(1);
                end else if (clr_seen_reg || oc_clr) begin
                  state_reg    <= S_RUN;
                  fault_reg    <= 1'b0;
                  dir_q_reg    <= dir[gi];
                  cur_reg      <= '0;
                  clr_seen_reg <= 1'b0;
                end
              end
            end
            default: state_reg <= S_DEAD;
          endcase
        end
      end
    end

    assign EN[gi]          = en_reg;
    assign IN[2*gi +: 2]   = in_reg;
    assign fault[gi]       = fault_reg;
  end

endmodule

// File: tb/tb_pwm_bridge_ctrl.sv
// Directed bench for pwm_bridge_ctrl: per-period EN counts, bridge states,
// reversal coast, fault lockout/clear, channel independence and reset.
module tb_pwm_bridge_ctrl;
  localparam int CH = 2, CW = 8, PERIOD = 10, STEP = 4, DEAD = 1, LOCKOUT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH*CW-1:0] duty = '0;
  logic [CH-1:0]    dir = '0;
  logic [CH-1:0]    OC = '0;
  logic             oc_clr = 1'b0;
  logic [CH-1:0]    EN;
  logic [2*CH-1:0]  IN;
  logic [CH-1:0]    fault;
  logic             period_start;

  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [3:0] prev_in = '0;

  always #5 clk = ~clk;

  pwm_bridge_ctrl #(
    .CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP), .DEAD(DEAD), .LOCKOUT(LOCKOUT)
  ) dut (
    .clk(clk), .rst(rst), .duty(duty), .dir(dir), .OC(OC), .oc_clr(oc_clr),
    .EN(EN), .IN(IN), .fault(fault), .period_start(period_start)
  );

  // safety properties watched on every cycle
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (EN[c] && IN[2*c +: 2] == 2'b00) viol++;
        if ((prev_in[2*c +: 2] == 2'b10 && IN[2*c +: 2] == 2'b01) ||
            (prev_in[2*c +: 2] == 2'b01 && IN[2*c +: 2] == 2'b10)) viol++;
      end
    end
    prev_in = IN;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic set_duty(input int ch, input int v);
    duty[ch*CW +: CW] = CW'(v);
  endtask

  // Observe one period window (starts with the period_start cycle), optionally
  // pulsing oc_clr / OC at given cycles and snapshotting outputs at snap_k.
  task automatic run_period(input int clr_k, input logic [1:0] oc_v, input int oc_from,
                            input int oc_to, input int snap_k,
                            output int c0, output int c1, output logic [3:0] in_first,
                            output logic [1:0] steady, output logic [1:0] flt_first,
                            output logic [1:0] flt_last, output logic ps_ok,
                            output logic [1:0] s_en, output logic [3:0] s_in,
                            output logic [1:0] s_flt);
    c0 = 0; c1 = 0; steady = 2'b11; ps_ok = 1'b1;
    in_first = '0; flt_first = '0; flt_last = '0; s_en = '0; s_in = '0; s_flt = '0;
    for (int k = 1; k <= PERIOD; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_first  = IN;
        flt_first = fault;
        if (period_start !== 1'b1) ps_ok = 1'b0;
      end else begin
        if (IN[1:0] !== in_first[1:0]) steady[0] = 1'b0;
        if (IN[3:2] !== in_first[3:2]) steady[1] = 1'b0;
        if (period_start !== 1'b0) ps_ok = 1'b0;
      end
      if (EN[0]) c0++;
      if (EN[1]) c1++;
      if (k == PERIOD) flt_last = fault;
      if (k == snap_k) begin s_en = EN; s_in = IN; s_flt = fault; end
      oc_clr = (k == clr_k);
      OC = (k >= oc_from && k < oc_to) ? oc_v : 2'b00;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; duty = '0; dir = '0; OC = '0; oc_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (EN !== 2'b00) begin bad++; $display("FAIL reset_en got=%b exp=00", EN); end
    total++; if (IN !== 4'b0000) begin bad++; $display("FAIL reset_in got=%b exp=0000", IN); end
    total++; if (fault !== 2'b00) begin bad++; $display("FAIL reset_fault got=%b exp=00", fault); end
    total++; if (period_start !== 1'b0) begin bad++; $display("FAIL reset_ps got=%b exp=0", period_start); end
    $display("reset: EN=%b IN=%b fault=%b ps=%b", EN, IN, fault, period_start);
    set_duty(0, 6); set_duty(1, 3);
    rst = 1'b0;
  endtask

  task automatic test_ramp_up(input string tag);
    int e0[5] = '{0, 0, 4, 6, 6};
    int e1[5] = '{0, 0, 3, 3, 3};
    int c0, c1; logic [3:0] inf; logic [1:0] st, ff, fl, se, sf; logic ps; logic [3:0] si;
    logic [1:0] ein;
    for (int w = 0; w < 5; w++) begin
      run_period(0, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
      ein = (w == 0) ? 2'b00 : 2'b10;
      $display("%s p%0d: en0=%0d en1=%0d IN=%b ps_ok=%b", tag, w, c0, c1, inf, ps);
      total++; if (c0 !== e0[w]) begin bad++; $display("FAIL %s_cnt0 p%0d got=%0d exp=%0d", tag, w, c0, e0[w]); end
      total++; if (c1 !== e1[w]) begin bad++; $display("FAIL %s_cnt1 p%0d got=%0d exp=%0d", tag, w, c1, e1[w]); end
      total++; if (inf[1:0] !== ein || st[0] !== 1'b1) begin bad++; $display("FAIL %s_in0 p%0d got=%b steady=%b exp=%b", tag, w, inf[1:0], st[0], ein); end
      total++; if (inf[3:2] !== ein || st[1] !== 1'b1) begin bad++; $display("FAIL %s_in1 p%0d got=%b steady=%b exp=%b", tag, w, inf[3:2], st[1], ein); end
      total++; if (ps !== 1'b1) begin bad++; $display("FAIL %s_ps p%0d got=%b exp=1", tag, w, ps); end
      total++; if (ff !== 2'b00) begin bad++; $display("FAIL %s_fault p%0d got=%b exp=00", tag, w, ff); end
    end
  endtask

  task automatic test_saturation_ramp_down();
    int e0[7] = '{6, 10, 10, 10, 6, 2, 0};
    int c0, c1; logic [3:0] inf; logic [1:0] st, ff, fl, se, sf; logic ps; logic [3:0] si;
    set_duty(0, 255);
    for (int w = 0; w < 7; w++) begin
      if (w == 3) set_duty(0, 0);
      run_period(0, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
      $display("sat p%0d: en0=%0d en1=%0d IN=%b", w, c0, c1, inf);
      total++; if (c0 !== e0[w]) begin bad++; $display("FAIL sat_cnt0 p%0d got=%0d exp=%0d", w, c0, e0[w]); end
      total++; if (c1 !== 3) begin bad++; $display("FAIL sat_cnt1 p%0d got=%0d exp=3", w, c1); end
    end
  endtask

  task automatic test_reversal();
    int e0[8] = '{0, 4, 6, 6, 0, 0, 4, 6};
    logic [1:0] ei[8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
    int c0, c1; logic [3:0] inf; logic [1:0] st, ff, fl, se, sf; logic ps; logic [3:0] si;
    set_duty(0, 6);
    for (int w = 0; w < 8; w++) begin
      if (w == 3) dir[0] = 1'b1;
      run_period(0, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
      $display("rev p%0d: en0=%0d IN0=%b steady=%b", w, c0, inf[1:0], st[0]);
      total++; if (c0 !== e0[w]) begin bad++; $display("FAIL rev_cnt0 p%0d got=%0d exp=%0d", w, c0, e0[w]); end
      total++; if (inf[1:0] !== ei[w] || st[0] !== 1'b1) begin bad++; $display("FAIL rev_in0 p%0d got=%b steady=%b exp=%b", w, inf[1:0], st[0], ei[w]); end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL rev_safety got=%0d exp=0", viol); end
  endtask

  task automatic test_fault_clear();
    int c0, c1; logic [3:0] inf; logic [1:0] st, ff, fl, se, sf; logic ps; logic [3:0] si;
    int e0[3] = '{0, 4, 6};
    run_period(0, 2'b01, 3, 6, 7, c0, c1, inf, st, ff, fl, ps, se, si, sf);
    $display("fault entry: EN=%b IN=%b fault=%b en1=%0d", se, si, sf, c1);
    total++; if (se[0] !== 1'b0) begin bad++; $display("FAIL oc_en0 got=%b exp=0", se[0]); end
    total++; if (si[1:0] !== 2'b00) begin bad++; $display("FAIL oc_in0 got=%b exp=00", si[1:0]); end
    total++; if (sf !== 2'b01) begin bad++; $display("FAIL oc_fault got=%b exp=01", sf); end
    total++; if (c1 !== 3) begin bad++; $display("FAIL oc_cnt1 got=%0d exp=3", c1); end
    run_period(2, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
    $display("early clr: en0=%0d IN0=%b fault=%b", c0, inf[1:0], fl);
    total++; if (fl[0] !== 1'b1) begin bad++; $display("FAIL early_clr_fault got=%b exp=1", fl[0]); end
    total++; if (c0 !== 0 || inf[1:0] !== 2'b00) begin bad++; $display("FAIL early_clr_out got=%0d/%b exp=0/00", c0, inf[1:0]); end
    run_period(2, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
    $display("clr: fault first=%b last=%b en0=%0d", ff, fl, c0);
    total++; if (ff[0] !== 1'b1) begin bad++; $display("FAIL clr_fault_hold got=%b exp=1", ff[0]); end
    total++; if (fl[0] !== 1'b0) begin bad++; $display("FAIL clr_fault_drop got=%b exp=0", fl[0]); end
    for (int w = 0; w < 3; w++) begin
      run_period(0, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
      $display("restart p%0d: en0=%0d IN0=%b", w, c0, inf[1:0]);
      total++; if (c0 !== e0[w]) begin bad++; $display("FAIL restart_cnt0 p%0d got=%0d exp=%0d", w, c0, e0[w]); end
      total++; if (inf[1:0] !== 2'b01) begin bad++; $display("FAIL restart_in0 p%0d got=%b exp=01", w, inf[1:0]); end
    end
  endtask

  task automatic test_independence_reset();
    int c0, c1; logic [3:0] inf; logic [1:0] st, ff, fl, se, sf; logic ps; logic [3:0] si;
    run_period(0, 2'b10, 3, 6, 7, c0, c1, inf, st, ff, fl, ps, se, si, sf);
    $display("ch1 fault: en0=%0d IN0=%b snap EN=%b IN=%b fault=%b", c0, inf[1:0], se, si, sf);
    total++; if (sf !== 2'b10 || se[1] !== 1'b0 || si[3:2] !== 2'b00) begin bad++; $display("FAIL ind_fault1 got=%b/%b/%b exp=10/0/00", sf, se[1], si[3:2]); end
    total++; if (c0 !== 6 || inf[1:0] !== 2'b01 || st[0] !== 1'b1) begin bad++; $display("FAIL ind_ch0 got=%0d/%b exp=6/01", c0, inf[1:0]); end
    run_period(0, 2'b00, 0, 0, 0, c0, c1, inf, st, ff, fl, ps, se, si, sf);
    $display("ch1 lockout: en0=%0d en1=%0d IN=%b fault=%b", c0, c1, inf, ff);
    total++; if (c0 !== 6 || c1 !== 0) begin bad++; $display("FAIL ind_cnts got=%0d/%0d exp=6/0", c0, c1); end
    total++; if (inf !== 4'b0001 || ff !== 2'b10) begin bad++; $display("FAIL ind_state got=%b/%b exp=0001/10", inf, ff); end
    repeat (3) @(negedge clk);
    rst = 1'b1; dir = '0;
    @(negedge clk);
    $display("mid-fault reset: EN=%b IN=%b fault=%b ps=%b", EN, IN, fault, period_start);
    total++; if ({EN, IN, fault, period_start} !== 9'b0) begin bad++; $display("FAIL rst_outputs got=%b exp=000000000", {EN, IN, fault, period_start}); end
    @(negedge clk);
    rst = 1'b0;
    test_ramp_up("rerun");
  endtask

  initial begin
    test_reset();
    test_ramp_up("ramp");
    test_saturation_ramp_down();
    test_reversal();
    test_fault_clear();
    test_independence_reset();
    total++; if (viol !== 0) begin bad++; $display("FAIL safety got=%0d exp=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
